// File: rtl/uart_packet_loader.sv
// rtl/uart_packet_loader.sv - length-prefixed checksummed packet parser with payload buffer
// Optional inter-byte timeout: define LOADER_TIMEOUT_EN.
module uart_packet_loader #(
   parameter int DEPTH          = 16,
   parameter int ADDR_W         = 4,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic              CLK_UART_i,
   input  logic              RST_UART_i,
   input  logic [7:0]        rx_data_i,
   input  logic              rx_valid_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [7:0]        rd_data_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic [1:0]        err_code_o,
   output logic [ADDR_W:0]   len_o
);

   typedef enum logic [1:0] {S_IDLE, S_LEN, S_DATA, S_CSUM} state_t;

   state_t            state, state_d;
   logic [7:0]        mem [DEPTH];
   logic [ADDR_W:0]   len_q, len_q_d, len_d;
   logic [ADDR_W-1:0] cnt, cnt_d;
   logic [7:0]        sum, sum_d, sum_next;
   logic              done_d, err_d, wr_en, timeout;
   logic [1:0]        code_d;

`ifdef LOADER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   logic [TW-1:0] tmo_cnt;

   always_ff @(posedge CLK_UART_i or posedge RST_UART_i) begin
      if (RST_UART_i)
         tmo_cnt <= '0;
      else if (rx_valid_i || state == S_IDLE)
         tmo_cnt <= '0;
      else
         tmo_cnt <= tmo_cnt + 1'b1;
   end

   // A byte in the same cycle wins over the timeout
   assign timeout = (state != S_IDLE) && !rx_valid_i && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
   assign timeout = 1'b0;
`endif

   assign sum_next = sum + rx_data_i;
   assign busy_o   = (state != S_IDLE);

   always_comb begin
      state_d = state;
      len_q_d = len_q;
      cnt_d   = cnt;
      sum_d   = sum;
      done_d  = 1'b0;
      err_d   = 1'b0;
      code_d  = err_code_o;
      len_d   = len_o;
      wr_en   = 1'b0;
      if (rx_valid_i) begin
         case (state)
            S_IDLE: if (rx_data_i == 8'hA5) state_d = S_LEN;
            S_LEN: begin
               if (rx_data_i == 8'd0 || rx_data_i > 8'(DEPTH)) begin
                  err_d   = 1'b1;
                  code_d  = 2'd1;
                  state_d = S_IDLE;
               end else begin
                  len_q_d = rx_data_i[ADDR_W:0];
                  cnt_d   = '0;
                  sum_d   = rx_data_i;
                  state_d = S_DATA;
               end
            end
            S_DATA: begin
               wr_en = 1'b1;
               sum_d = sum_next;
               cnt_d = cnt + 1'b1;
               if ({1'b0, cnt} == len_q - 1'b1) state_d = S_CSUM;
            end
            S_CSUM: begin
               if (sum_next == 8'd0) begin
                  done_d = 1'b1;
                  len_d  = len_q;
               end else begin
                  err_d  = 1'b1;
                  code_d = 2'd2;
               end
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end else if (timeout) begin
         err_d   = 1'b1;
         code_d  = 2'd3;
         state_d = S_IDLE;
      end
   end

   always_ff @(posedge CLK_UART_i or posedge RST_UART_i) begin
      if (RST_UART_i) begin
         state      <= S_IDLE;
         len_q      <= '0;
         cnt        <= '0;
         sum        <= '0;
         done_o     <= 1'b0;
         err_o      <= 1'b0;
         err_code_o <= 2'd0;
         len_o      <= '0;
         rd_data_o  <= 8'd0;
      end else begin
         state      <= state_d;
         len_q      <= len_q_d;
         cnt        <= cnt_d;
         sum        <= sum_d;
         done_o     <= done_d;
         err_o      <= err_d;
         err_code_o <= code_d;
         len_o      <= len_d;
         rd_data_o  <= mem[rd_addr_i];
      end
   end

   // Buffer is deliberately left out of reset so it maps onto block RAM
   always_ff @(posedge CLK_UART_i) begin
      if (wr_en) mem[cnt] <= rx_data_i;
   end

endmodule

// File: tb/tb_uart_packet_loader.sv
// tb/tb_uart_packet_loader.sv - scoreboard bench for uart_packet_loader
module tb_uart_packet_loader;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [3:0] rd_addr;
   logic [7:0] rd_data;
   logic       busy, done, err;
   logic [1:0] err_code;
   logic [4:0] len_out;

   uart_packet_loader #(.DEPTH(16), .ADDR_W(4), .TIMEOUT_CYCLES(100)) dut (
      .CLK_UART_i (clk),
      .RST_UART_i (rst),
      .rx_data_i  (rx_data),
      .rx_valid_i (rx_valid),
      .rd_addr_i  (rd_addr),
      .rd_data_o  (rd_data),
      .busy_o     (busy),
      .done_o     (done),
      .err_o      (err),
      .err_code_o (err_code),
      .len_o      (len_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit is_err;
      int code;
      int len;
   } ev_t;

   ev_t        expq[$];
   int         rdq[$];
   int         checks = 0;
   int         errors = 0;
   logic [7:0] model_mem [16];
   int         model_len = 0;
   int         model_code = 0;
   logic [7:0] pk_data [256];
   bit         rd_req = 1'b0;
   bit         rd_pend = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT reports an outcome or read data
   always @(negedge clk) begin
      if (rd_pend) begin
         if (rdq.size() == 0) chk("rd_unexpected", 1, 0);
         else chk("rd_data", int'(rd_data), rdq.pop_front());
      end
      rd_pend <= rd_req;
      if (done && err) chk("done_and_err", 1, 0);
      if (done || err) begin
         if (expq.size() == 0) begin
            chk("unexpected_event", 1, 0);
         end else begin
            ev_t e;
            e = expq.pop_front();
            chk("event_is_err", int'(err), int'(e.is_err));
            chk("event_code", int'(err_code), e.code);
            chk("event_len", int'(len_out), e.len);
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (expq.size() != 0 && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      if (expq.size() != 0) begin
         chk("event_timeout", expq.size(), 0);
         expq.delete();
      end
      chk("busy_after", int'(busy), 0);
   endtask

   task automatic read_back(input int n);
      for (int a = 0; a < n; a++) begin
         rdq.push_back(int'(model_mem[a]));
         rd_addr = 4'(a);
         rd_req  = 1'b1;
         @(posedge clk); #1;
      end
      rd_req = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
   endtask

   // pk_data[0..lenb-1] must be filled by the caller when lenb is legal
   task automatic send_packet(input int njunk, input logic [7:0] lenb, input bit csum_ok);
      logic [7:0] s, c, j;
      for (int i = 0; i < njunk; i++) begin
         j = 8'($urandom);
         if (j == 8'hA5) j = 8'h5A;
         send_byte(j, $urandom_range(2));
      end
      send_byte(8'hA5, 0);
      chk("busy_hdr", int'(busy), 1);
      if (lenb == 8'd0 || lenb > 8'd16) begin
         model_code = 1;
         expq.push_back('{1'b1, 1, model_len});
         send_byte(lenb, $urandom_range(2));
         wait_idle(20);
         return;
      end
      send_byte(lenb, $urandom_range(2));
      s = lenb;
      for (int i = 0; i < int'(lenb); i++) begin
         s = s + pk_data[i];
         send_byte(pk_data[i], $urandom_range(2));
      end
      c = 8'h00 - s;
      if (!csum_ok) c = c + 8'($urandom_range(255, 1));
      if (csum_ok) begin
         model_len = int'(lenb);
         for (int i = 0; i < int'(lenb); i++) model_mem[i] = pk_data[i];
         expq.push_back('{1'b0, model_code, model_len});
      end else begin
         model_code = 2;
         expq.push_back('{1'b1, 2, model_len});
      end
      send_byte(c, $urandom_range(2));
      wait_idle(20);
      if (csum_ok) read_back(int'(lenb));
   endtask

   initial begin
      rst = 1'b1; rx_valid = 1'b0; rx_data = 8'd0; rd_addr = 4'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_code", int'(err_code), 0);
      chk("rst_len", int'(len_out), 0);
      chk("rst_rd_data", int'(rd_data), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      pk_data[0] = 8'h11; pk_data[1] = 8'h22; pk_data[2] = 8'h33;
      send_packet(0, 8'd3, 1'b1);
      chk("len_after_good", int'(len_out), 3);

      // Leading junk is skipped; 0xA5 as payload is ordinary data
      send_byte(8'h00, 0);
      send_byte(8'hFF, 1);
      pk_data[0] = 8'hA5;
      send_packet(0, 8'd1, 1'b1);

      pk_data[0] = 8'h11; pk_data[1] = 8'h22; pk_data[2] = 8'h33;
      send_packet(0, 8'd3, 1'b0);
      chk("len_kept_on_err", int'(len_out), 1);

      send_packet(0, 8'd0, 1'b1);
      send_packet(0, 8'h11, 1'b1);

      for (int i = 0; i < 16; i++) pk_data[i] = 8'($urandom);
      send_packet(1, 8'd16, 1'b1);

      // Reset mid-packet: abort, no error pulse, len cleared
      send_byte(8'hA5, 0);
      send_byte(8'h03, 0);
      send_byte(8'h11, 0);
      #2 rst = 1'b1;
      #1;
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_len", int'(len_out), 0);
      chk("midrst_code", int'(err_code), 0);
      model_len = 0;
      model_code = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      pk_data[0] = 8'h42; pk_data[1] = 8'h99;
      send_packet(0, 8'd2, 1'b1);

      for (int p = 0; p < 30; p++) begin
         int kind;
         logic [7:0] lenb;
         kind = $urandom_range(9);
         if (kind == 0)
            lenb = ($urandom_range(1) == 1) ? 8'd0 : 8'($urandom_range(255, 17));
         else
            lenb = 8'($urandom_range(16, 1));
         for (int i = 0; i < 16; i++)
            pk_data[i] = ($urandom_range(7) == 0) ? 8'hA5 : 8'($urandom);
         send_packet($urandom_range(3), lenb, kind > 2);
      end

`ifdef LOADER_TIMEOUT_EN
      send_byte(8'hA5, 0);
      send_byte(8'h02, 0);
      model_code = 3;
      expq.push_back('{1'b1, 3, model_len});
      send_byte(8'h10, 0);
      wait_idle(200);
`endif

      repeat (3) @(posedge clk);
      #1;
      chk("expq_empty", expq.size(), 0);
      chk("rdq_empty", rdq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
